step_debounce: RTL and testbench
================================

STEP_DEBOUNCE -- requirements
Module: step_debounce

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, is the number of consecutive CLK cycles a synchronized input must differ from its stable value before it is accepted (10 ms at 100 MHz).
REQ-002 Parameter RPT_DLY, default 50000000, is the number of CLK cycles the button is held after the first STEP before auto-repeat starts.
REQ-003 Parameter RPT_PER, default 25000000, is the number of CLK cycles between auto-repeat STEP pulses.
REQ-004 All three parameters SHALL be at least 1, and all internal cycle counters SHALL be 32 bits wide.
REQ-005 CLK  in  1  100 MHz board clock; every register is clocked on its rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 PBC  in  1  raw single-step pushbutton, asynchronous and bouncing.
REQ-008 SW  in  3  raw switches {x3,x2,x1}, asynchronous and bouncing.
REQ-009 REPEAT_EN  in  1  auto-repeat enable, quasi-static and synchronized internally.
REQ-010 STEP  out  1  one-CLK-cycle pulse that advances the downstream state machine.
REQ-011 X_Q  out  3  debounced switch values captured at each STEP, held stable between steps.
REQ-012 PBC_DB  out  1  debounced button level, intended to drive LEDPBC.
REQ-013 STEP_CNT  out  8  count of STEP pulses issued.

Function
REQ-014 PBC, each SW bit and REPEAT_EN SHALL each pass through a two-flop synchronizer before any other logic uses them.
REQ-015 Each of the four debounced signals (PBC, SW[2:0]) SHALL have its own stable register and counter; the counter clears whenever the synchronized value equals the stable value.
REQ-016 When a debounced signal's counter reaches DB_CYCLES-1 while the synchronized value still differs, the stable value SHALL toggle on that edge and the counter SHALL clear.
REQ-017 A glitch shorter than DB_CYCLES cycles SHALL NOT change the stable value.
REQ-018 Latency: PBC_DB SHALL change exactly DB_CYCLES+2 cycles after the first CLK edge that samples the new raw PBC level, provided the raw level holds.
REQ-019 The FSM SHALL have three states: IDLE, PRESSED and REPEAT.
REQ-020 IDLE -> PRESSED on the first cycle PBC_DB=1; STEP SHALL assert in the following cycle, and the hold counter SHALL clear.
REQ-021 In PRESSED with synchronized REPEAT_EN=1, the hold counter SHALL increment each cycle; on reaching RPT_DLY-1 the FSM SHALL move to REPEAT, issue one STEP and clear the counter.
REQ-022 In REPEAT, a STEP SHALL issue every RPT_PER cycles, with the counter wrapping to 0 at RPT_PER-1.
REQ-023 While synchronized REPEAT_EN=0 in PRESSED or REPEAT, the FSM SHALL go to or stay in PRESSED with the counter held at 0 and issue no further STEP.
REQ-024 PBC_DB=0 in any state SHALL force IDLE with no STEP; release takes priority over a repeat pulse due in the same cycle.
REQ-025 STEP SHALL never be high for two consecutive cycles.
REQ-026 X_Q SHALL load the three debounced SW values on the same edge that sets STEP high, so X_Q is valid during the STEP cycle.
REQ-027 X_Q SHALL hold between STEP pulses regardless of switch motion.
REQ-028 STEP_CNT SHALL increment by 1 on each STEP and wrap 255 -> 0.

Reset
REQ-029 While RST_N=0, the following SHALL be 0 and the FSM SHALL be in IDLE: all synchronizer flops, stable registers, counters, STEP, X_Q, PBC_DB and STEP_CNT.
REQ-030 Reset assertion SHALL take effect immediately without a clock edge, and an in-progress press or repeat SHALL be abandoned.
REQ-031 If PBC is held through reset deassertion, it SHALL be treated as a new press: one STEP is issued DB_CYCLES+3 cycles after the first post-reset edge that samples PBC=1.

Verification (DB_CYCLES=4, RPT_DLY=20, RPT_PER=8)
REQ-032 Clean press: PBC rises and holds with SW=3'b101 stable -> PBC_DB=1 after 6 cycles; STEP high for exactly 1 cycle on the next cycle, with X_Q=3'b101 and STEP_CNT=1.
REQ-033 Bounce: PBC toggles 1,0,1,0 at 2-cycle intervals, then holds 1 -> exactly one STEP, 7 cycles after the final rising sample; a 3-cycle pulse alone produces no STEP.
REQ-034 Auto-repeat: REPEAT_EN=1, PBC held for 60 cycles after the first STEP -> second STEP 20 cycles after the first, then every 8 cycles; release gives no STEP after PBC_DB falls.
REQ-035 REPEAT_EN dropped mid-REPEAT -> no further STEP while held; re-raising it restarts the 20-cycle delay.
REQ-036 Wrap and reset: 256 steps -> STEP_CNT returns to 0; RST_N pulsed low mid-hold -> all outputs 0 immediately and one fresh STEP issued after release per REQ-031.

Source files
------------

// File: rtl/step_debounce.sv
// Single-step pushbutton front end: synchronizes and debounces PBC/SW, then
// issues one-cycle STEP pulses with optional hold-to-auto-repeat.
module step_debounce #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned RPT_DLY   = 50000000,
  parameter int unsigned RPT_PER   = 25000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PBC,
  input  logic [2:0] SW,
  input  logic       REPEAT_EN,
  output logic       STEP,
  output logic [2:0] X_Q,
  output logic       PBC_DB,
  output logic [7:0] STEP_CNT
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned NDB   = 4;
  localparam int unsigned PBC_I = 3;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PER - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2
  } state_t;

  logic [NDB-1:0]   raw;
  logic [NDB-1:0]   meta;
  logic [NDB-1:0]   sync;
  logic [NDB-1:0]   stable;
  logic [CNT_W-1:0] db_cnt [NDB];
  logic             rep_meta;
  logic             rep_sync;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             step_c;

  assign raw = {PBC, SW};

  // Two-flop synchronizers for every asynchronous input.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta     <= '0;
      sync     <= '0;
      rep_meta <= 1'b0;
      rep_sync <= 1'b0;
    end else begin
      meta     <= raw;
      sync     <= meta;
      rep_meta <= REPEAT_EN;
      rep_sync <= rep_meta;
    end
  end

  // Per-signal debouncers: the stable value flips after DB_CYCLES differing cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stable <= '0;
      for (int i = 0; i < NDB; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NDB; i++) begin
        if (sync[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state logic; release wins over any repeat pulse due this cycle.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    step_c    = 1'b0;
    if (!PBC_DB) begin
      state_nxt = S_IDLE;
      hold_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_PRESSED;
          hold_nxt  = '0;
          step_c    = 1'b1;
        end
        S_PRESSED: begin
          if (!rep_sync) begin
            hold_nxt = '0;
          end else if (hold_cnt == DLY_LAST) begin
            state_nxt = S_REPEAT;
            hold_nxt  = '0;
            step_c    = ~STEP;
          end else begin
            hold_nxt = hold_cnt + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!rep_sync) begin
            state_nxt = S_PRESSED;
            hold_nxt  = '0;
          end else if (hold_cnt == PER_LAST) begin
            hold_nxt = '0;
            step_c   = ~STEP;
          end else begin
            hold_nxt = hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // Registered outputs; X_Q snapshots the debounced switches with each STEP.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STEP     <= 1'b0;
      X_Q      <= '0;
      PBC_DB   <= 1'b0;
      STEP_CNT <= '0;
    end else begin
      STEP   <= step_c;
      PBC_DB <= stable[PBC_I];
      if (step_c) begin
        X_Q      <= stable[2:0];
        STEP_CNT <= STEP_CNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_step_debounce.sv
// Bench for step_debounce: directed table and hand sequences with constant
// expectations, then random stimulus against an event-level reference model.
module tb_step_debounce;

  localparam int unsigned DB  = 4;
  localparam int unsigned DLY = 20;
  localparam int unsigned PER = 8;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       PBC;
  logic [2:0] SW;
  logic       REPEAT_EN;
  logic       STEP;
  logic [2:0] X_Q;
  logic       PBC_DB;
  logic [7:0] STEP_CNT;

  int n_cmp = 0;
  int n_bad = 0;

  step_debounce #(.DB_CYCLES(DB), .RPT_DLY(DLY), .RPT_PER(PER)) dut (
    .CLK(CLK), .RST_N(RST_N), .PBC(PBC), .SW(SW), .REPEAT_EN(REPEAT_EN),
    .STEP(STEP), .X_Q(X_Q), .PBC_DB(PBC_DB), .STEP_CNT(STEP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run_count(input int n, output int steps);
    steps = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (STEP === 1'b1) steps++;
    end
  endtask

  // Reference model: inputs are delayed two edges, a debounced level flips
  // once its last DB samples all disagree with it, and steps are derived
  // from how long the button has been held with repeat enabled.
  logic [3:0] m_s1, m_s2, m_stable;
  logic       m_r1, m_r2;
  bit         m_hist [4][DB];
  logic       m_db, m_prev_db, m_step;
  logic [2:0] m_xq;
  logic [7:0] m_cnt;
  int         m_run;

  initial begin
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_r1 = 1'b0; m_r2 = 1'b0;
        m_db = 1'b0; m_prev_db = 1'b0; m_step = 1'b0; m_xq = '0; m_cnt = '0; m_run = 0;
        for (int i = 0; i < 4; i++) for (int k = 0; k < DB; k++) m_hist[i][k] = 1'b0;
      end else begin
        logic press, stp;
        press = m_db && !m_prev_db;
        if (m_db && !press && m_r2) m_run++;
        else m_run = 0;
        stp = press || (m_run >= DLY && ((m_run - DLY) % PER) == 0);
        if (stp) begin
          m_xq  = m_stable[2:0];
          m_cnt = m_cnt + 8'd1;
        end
        m_step    = stp;
        m_prev_db = m_db;
        m_db      = m_stable[3];
        for (int i = 0; i < 4; i++) begin
          bit all_diff;
          for (int k = DB - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
          m_hist[i][0] = m_s2[i];
          all_diff = 1'b1;
          for (int k = 0; k < DB; k++) if (m_hist[i][k] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) m_stable[i] = ~m_stable[i];
        end
        m_s2 = m_s1; m_s1 = {PBC, SW};
        m_r2 = m_r1; m_r1 = REPEAT_EN;
      end
    end
  end

  typedef struct {
    logic [2:0] sw;
    int         hold;
    logic       rep;
    int         steps;
    logic [2:0] xq;
  } row_t;

  row_t rows [6];

  initial begin
    int steps, exp_cnt, step_at, total;
    int pbc_left;

    rows[0] = '{sw: 3'b101, hold: 3,  rep: 1'b0, steps: 0, xq: 3'b101};
    rows[1] = '{sw: 3'b101, hold: 10, rep: 1'b0, steps: 1, xq: 3'b101};
    rows[2] = '{sw: 3'b011, hold: 30, rep: 1'b0, steps: 1, xq: 3'b011};
    rows[3] = '{sw: 3'b110, hold: 67, rep: 1'b1, steps: 7, xq: 3'b110};
    rows[4] = '{sw: 3'b010, hold: 20, rep: 1'b1, steps: 1, xq: 3'b010};
    rows[5] = '{sw: 3'b111, hold: 21, rep: 1'b1, steps: 2, xq: 3'b111};

    RST_N = 1'b0; PBC = 1'b0; SW = 3'b000; REPEAT_EN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_step", 32'(STEP), 0);
    chk("rst_xq", 32'(X_Q), 0);
    chk("rst_pbc_db", 32'(PBC_DB), 0);
    chk("rst_cnt", 32'(STEP_CNT), 0);
    RST_N = 1'b1;

    // Clean press: debounced level after 6 edges, single STEP on the 7th.
    SW = 3'b101;
    repeat (12) tick();
    PBC = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 5) chk("clean_db_early", 32'(PBC_DB), 0);
      if (k == 6) begin
        chk("clean_db_set", 32'(PBC_DB), 1);
        chk("clean_step_early", 32'(STEP), 0);
      end
      if (k == 7) begin
        chk("clean_step", 32'(STEP), 1);
        chk("clean_xq", 32'(X_Q), 32'(3'b101));
        chk("clean_cnt", 32'(STEP_CNT), 1);
      end
      if (k == 8) chk("clean_step_one_cycle", 32'(STEP), 0);
    end
    PBC = 1'b0;
    run_count(20, steps);
    chk("clean_release_steps", steps, 0);
    exp_cnt = 1;

    for (int r = 0; r < 6; r++) begin
      SW = rows[r].sw; REPEAT_EN = rows[r].rep; PBC = 1'b0;
      repeat (12) tick();
      PBC = 1'b1;
      run_count(rows[r].hold, steps);
      PBC = 1'b0;
      run_count(20, total);
      total += steps;
      exp_cnt += rows[r].steps;
      chk($sformatf("row%0d_steps", r), total, rows[r].steps);
      chk($sformatf("row%0d_xq", r), 32'(X_Q), 32'(rows[r].xq));
      chk($sformatf("row%0d_cnt", r), 32'(STEP_CNT), 32'(exp_cnt & 255));
      chk($sformatf("row%0d_db_low", r), 32'(PBC_DB), 0);
    end

    // Bounce 1,0,1,0 at 2-cycle intervals then hold: one STEP, 7 edges after final rise.
    REPEAT_EN = 1'b0;
    repeat (4) tick();
    total = 0; step_at = -1;
    for (int k = 0; k < 30; k++) begin
      PBC = (k < 2 || (k >= 4 && k < 6) || k >= 8) ? 1'b1 : 1'b0;
      tick();
      if (STEP === 1'b1) begin
        total++;
        if (step_at < 0) step_at = k;
      end
    end
    chk("bounce_steps", total, 1);
    chk("bounce_latency", step_at - 8, 7);
    PBC = 1'b0;
    run_count(20, steps);
    exp_cnt += 1;

    // Drop REPEAT_EN mid-repeat, then re-raise it to restart the delay.
    REPEAT_EN = 1'b1;
    repeat (4) tick();
    PBC = 1'b1;
    run_count(40, steps);
    chk("rep_first_steps", steps, 3);
    REPEAT_EN = 1'b0;
    run_count(30, steps);
    chk("rep_off_steps", steps, 0);
    REPEAT_EN = 1'b1;
    step_at = -1;
    for (int k = 0; k < 40 && step_at < 0; k++) begin
      tick();
      if (STEP === 1'b1) step_at = k;
    end
    chk("rep_restart_delay", step_at, 21);
    PBC = 1'b0;
    run_count(20, steps);
    exp_cnt += 4;
    chk("rep_cnt", 32'(STEP_CNT), 32'(exp_cnt & 255));

    // 256 repeat pulses bring STEP_CNT back to its starting value.
    PBC = 1'b1;
    total = 0;
    for (int k = 0; k < 2400 && total < 256; k++) begin
      tick();
      if (STEP === 1'b1) total++;
    end
    chk("wrap_pulses", total, 256);
    chk("wrap_cnt", 32'(STEP_CNT), 32'(exp_cnt & 255));

    // Reset mid-hold: outputs clear without a clock edge; held button is a new press.
    repeat (3) tick();
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_step", 32'(STEP), 0);
    chk("midrst_xq", 32'(X_Q), 0);
    chk("midrst_pbc_db", 32'(PBC_DB), 0);
    chk("midrst_cnt", 32'(STEP_CNT), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    total = 0; step_at = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (STEP === 1'b1) begin
        total++;
        if (step_at < 0) step_at = k;
      end
    end
    chk("postrst_steps", total, 1);
    chk("postrst_latency", step_at, 7);
    chk("postrst_cnt", 32'(STEP_CNT), 1);
    PBC = 1'b0; REPEAT_EN = 1'b0;
    run_count(20, steps);

    // Random stimulus against the reference model.
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    pbc_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (pbc_left == 0) begin
        PBC = ~PBC;
        pbc_left = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 5))
                                                : int'($urandom_range(5, 70));
      end
      pbc_left--;
      if ($urandom_range(0, 39) == 0) SW = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) REPEAT_EN = ~REPEAT_EN;
      tick();
      chk("rnd_step", 32'(STEP), 32'(m_step));
      chk("rnd_pbc_db", 32'(PBC_DB), 32'(m_db));
      chk("rnd_xq", 32'(X_Q), 32'(m_xq));
      chk("rnd_cnt", 32'(STEP_CNT), 32'(m_cnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
